// File: rtl/mips_pkg.sv
// Shared types and constants for the scoreboard hazard unit.
package mips_pkg;

   // Entry fields are held at a fixed generous width; the top truncates to AW on output.
   localparam int unsigned SB_W = 8;

   localparam logic [1:0] LAT_ALU  = 2'd0;
   localparam logic [1:0] LAT_LOAD = 2'd1;
   localparam logic [1:0] LAT_MUL  = 2'd2;

   // Forward-select value meaning "take the operand from the regfile / ID-EX latch".
   localparam int unsigned FWD_RF = 0;

   typedef struct packed {
      logic [SB_W-1:0] age;
      logic [SB_W-1:0] ready;
   } sb_entry_t;

   // Producer age at which a result of class cls becomes forwardable; class 3 behaves as MUL.
   function automatic logic [SB_W-1:0] class_ready(input logic [1:0]      cls,
                                                   input logic [SB_W-1:0] load_rdy,
                                                   input logic [SB_W-1:0] mul_rdy);
      logic [SB_W-1:0] r;
      case (cls)
         LAT_ALU:  r = SB_W'(1);
         LAT_LOAD: r = load_rdy;
         default:  r = mul_rdy;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_sb_entry.sv
// One scoreboard entry: tracks the age and ready point of the youngest producer of a register.
module mips_sb_entry
   import mips_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_i,
   input  logic [SB_W-1:0] ready_i,
   output sb_entry_t       entry_o
);

   localparam logic [SB_W-1:0] DEPTH_V = SB_W'(PIPE_DEPTH);

   sb_entry_t entry_d;
   sb_entry_t entry_q;

   // A new producer restarts the entry at EX; otherwise a pending producer advances one stage.
   always_comb begin
      entry_d = entry_q;
      if (set_i) begin
         entry_d.age   = SB_W'(1);
         entry_d.ready = ready_i;
      end else if (entry_q.age != '0) begin
         if (entry_q.age == DEPTH_V) begin
            entry_d.age = '0;
         end else begin
            entry_d.age = entry_q.age + SB_W'(1);
         end
      end
   end

   // Entry state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign entry_o = entry_q;

endmodule

// File: rtl/mips_scoreboard_hazard_unit.sv
// Age-scoreboard hazard and forwarding controller sitting beside the ID stage.
module mips_scoreboard_hazard_unit
   import mips_pkg::*;
#(
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned PIPE_DEPTH = 3,
   parameter int unsigned LOAD_READY = 2,
   parameter int unsigned MUL_READY  = 3,
   parameter int unsigned AW         = $clog2(PIPE_DEPTH + 1)
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              IdValid,
   input  logic [REG_AW-1:0] IdRs,
   input  logic [REG_AW-1:0] IdRt,
   input  logic              IdUseRs,
   input  logic              IdUseRt,
   input  logic              IdEarlyUse,
   input  logic              IdWe,
   input  logic [REG_AW-1:0] IdDst,
   input  logic [1:0]        IdLatClass,
   input  logic              Flush,
   output logic              Stall,
   output logic              BubbleEx,
   output logic [AW-1:0]     FwdSelA,
   output logic [AW-1:0]     FwdSelB,
   output logic [AW-1:0]     IdFwdSelA,
   output logic [AW-1:0]     IdFwdSelB,
   output logic [15:0]       StallCycles
);

   localparam logic [SB_W-1:0] DEPTH_V    = SB_W'(PIPE_DEPTH);
   localparam logic [SB_W-1:0] LOAD_RDY_V = SB_W'(LOAD_READY);
   localparam logic [SB_W-1:0] MUL_RDY_V  = SB_W'(MUL_READY);
   localparam logic [AW-1:0]   SEL_RF     = AW'(FWD_RF);

   sb_entry_t       ent [NUM_REGS];
   logic            issue;
   logic            hazard_any;
   logic [SB_W-1:0] new_ready;

   logic [REG_AW-1:0] op_src  [2];
   logic              op_use  [2];
   logic              op_pend [2];
   logic              op_hz   [2];
   logic [AW-1:0]     op_fwd_ex [2];
   logic [AW-1:0]     op_fwd_id [2];

   logic [AW-1:0] fwd_sel_a_d, fwd_sel_a_q;
   logic [AW-1:0] fwd_sel_b_d, fwd_sel_b_q;
   logic [15:0]   stall_cycles_d, stall_cycles_q;

   assign ent[0]    = '0;
   assign new_ready = class_ready(IdLatClass, LOAD_RDY_V, MUL_RDY_V);

   // One entry per trackable register; r0 is hardwired idle.
   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      mips_sb_entry #(
         .PIPE_DEPTH (PIPE_DEPTH)
      ) u_entry (
         .clk     (Clk),
         .rst_n   (Rst_n),
         .set_i   (issue && IdWe && (IdDst == REG_AW'(gi))),
         .ready_i (new_ready),
         .entry_o (ent[gi])
      );
   end

   // Per-operand hazard test and forward-select candidates; Rs and Rt are independent.
   always_comb begin
      op_src[0] = IdRs;
      op_src[1] = IdRt;
      op_use[0] = IdUseRs;
      op_use[1] = IdUseRt;
      for (int i = 0; i < 2; i++) begin
         op_pend[i]   = op_use[i] && (op_src[i] != '0) && (ent[op_src[i]].age != '0);
         op_hz[i]     = 1'b0;
         op_fwd_ex[i] = SEL_RF;
         op_fwd_id[i] = SEL_RF;
         if (op_pend[i]) begin
            if (IdEarlyUse) begin
               op_hz[i] = ent[op_src[i]].age <= ent[op_src[i]].ready;
            end else begin
               op_hz[i] = ent[op_src[i]].age < ent[op_src[i]].ready;
            end
            if ((ent[op_src[i]].age >= ent[op_src[i]].ready) && (ent[op_src[i]].age < DEPTH_V)) begin
               op_fwd_ex[i] = AW'(ent[op_src[i]].age);
            end
            if (ent[op_src[i]].age > ent[op_src[i]].ready) begin
               op_fwd_id[i] = AW'(ent[op_src[i]].age - SB_W'(1));
            end
         end
      end
   end

   // Stall/issue decision and next values of the registered selects and counter.
   always_comb begin
      hazard_any     = op_hz[0] || op_hz[1];
      Stall          = IdValid && !Flush && hazard_any;
      BubbleEx       = Stall && IdValid && !Flush;
      issue          = IdValid && !Stall && !Flush;
      fwd_sel_a_d    = issue ? op_fwd_ex[0] : SEL_RF;
      fwd_sel_b_d    = issue ? op_fwd_ex[1] : SEL_RF;
      stall_cycles_d = stall_cycles_q;
      if (Stall && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end
   end

   // EX forward selects and stall performance counter.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         fwd_sel_a_q    <= SEL_RF;
         fwd_sel_b_q    <= SEL_RF;
         stall_cycles_q <= '0;
      end else begin
         fwd_sel_a_q    <= fwd_sel_a_d;
         fwd_sel_b_q    <= fwd_sel_b_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign FwdSelA     = fwd_sel_a_q;
   assign FwdSelB     = fwd_sel_b_q;
   assign IdFwdSelA   = op_fwd_id[0];
   assign IdFwdSelB   = op_fwd_id[1];
   assign StallCycles = stall_cycles_q;

endmodule

// File: tb/tb_mips_scoreboard_hazard_unit.sv
// Randomized and directed bench for the scoreboard hazard unit against a cycle-count model.
module tb_mips_scoreboard_hazard_unit;

   localparam int DEPTH    = 3;
   localparam int LOAD_RDY = 2;
   localparam int MUL_RDY  = 3;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic       IdValid, IdUseRs, IdUseRt, IdEarlyUse, IdWe, Flush;
   logic [4:0] IdRs, IdRt, IdDst;
   logic [1:0] IdLatClass;
   logic       Stall, BubbleEx;
   logic [1:0] FwdSelA, FwdSelB, IdFwdSelA, IdFwdSelB;
   logic [15:0] StallCycles;

   mips_scoreboard_hazard_unit dut (
      .Clk(Clk), .Rst_n(Rst_n), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
      .IdUseRs(IdUseRs), .IdUseRt(IdUseRt), .IdEarlyUse(IdEarlyUse), .IdWe(IdWe),
      .IdDst(IdDst), .IdLatClass(IdLatClass), .Flush(Flush), .Stall(Stall),
      .BubbleEx(BubbleEx), .FwdSelA(FwdSelA), .FwdSelB(FwdSelB),
      .IdFwdSelA(IdFwdSelA), .IdFwdSelB(IdFwdSelB), .StallCycles(StallCycles)
   );

   always #5 Clk = ~Clk;

   int n_pass = 0;
   int n_total = 0;

   // Model: producer of each register is remembered by the cycle number it issued on.
   int cyc = 0;
   int prod_cyc [32];
   int prod_rdy [32];
   int exp_fwd_a = 0, exp_fwd_b = 0, exp_cnt = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         prod_cyc[r] = -1000;
         prod_rdy[r] = 1;
      end
      exp_fwd_a = 0;
      exp_fwd_b = 0;
      exp_cnt   = 0;
   endtask

   // Stage currently holding the youngest producer of r, 0 when none is in flight.
   function automatic int age_of(input int r);
      int a;
      if (r == 0) return 0;
      a = cyc - prod_cyc[r] + 1;
      return (a >= 1 && a <= DEPTH) ? a : 0;
   endfunction

   function automatic int ready_of(input int cls);
      return (cls == 0) ? 1 : (cls == 1) ? LOAD_RDY : MUL_RDY;
   endfunction

   task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit early, input bit we, input int dst, input int cls, input bit fl);
      int  src [2];
      bit  used [2];
      int  a, rdy, fwd_ex [2], fwd_id [2];
      bit  hz, stall, issue;
      @(negedge Clk);
      IdValid = v; IdRs = 5'(rs); IdRt = 5'(rt); IdUseRs = urs; IdUseRt = urt;
      IdEarlyUse = early; IdWe = we; IdDst = 5'(dst); IdLatClass = 2'(cls); Flush = fl;
      #1;
      src[0] = rs; src[1] = rt; used[0] = urs; used[1] = urt;
      hz = 1'b0;
      for (int i = 0; i < 2; i++) begin
         a = used[i] ? age_of(src[i]) : 0;
         rdy = prod_rdy[src[i]];
         fwd_ex[i] = 0;
         fwd_id[i] = 0;
         if (a != 0) begin
            if (early ? (a <= rdy) : (a < rdy)) hz = 1'b1;
            if (a >= rdy && a < DEPTH) fwd_ex[i] = a;
            if (a > rdy) fwd_id[i] = a - 1;
         end
      end
      stall = v && !fl && hz;
      issue = v && !stall && !fl;
      check("stall",     int'(Stall),     int'(stall));
      check("bubble_ex", int'(BubbleEx),  int'(stall));
      check("id_fwd_a",  int'(IdFwdSelA), fwd_id[0]);
      check("id_fwd_b",  int'(IdFwdSelB), fwd_id[1]);
      @(posedge Clk);
      cyc++;
      if (issue && we && dst != 0) begin
         prod_cyc[dst] = cyc;
         prod_rdy[dst] = ready_of(cls);
      end
      exp_fwd_a = issue ? fwd_ex[0] : 0;
      exp_fwd_b = issue ? fwd_ex[1] : 0;
      if (stall && exp_cnt < 65535) exp_cnt++;
      #1;
      check("fwd_a",        int'(FwdSelA),     exp_fwd_a);
      check("fwd_b",        int'(FwdSelB),     exp_fwd_b);
      check("stall_cycles", int'(StallCycles), exp_cnt);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      model_reset();
      Rst_n = 1'b0;
      IdValid = 0; IdRs = 0; IdRt = 0; IdUseRs = 0; IdUseRt = 0; IdEarlyUse = 0;
      IdWe = 0; IdDst = 0; IdLatClass = 0; Flush = 0;
      #12;
      check("rst_stall",  int'(Stall),       0);
      check("rst_fwd_a",  int'(FwdSelA),     0);
      check("rst_fwd_b",  int'(FwdSelB),     0);
      check("rst_cnt",    int'(StallCycles), 0);
      @(negedge Clk);
      Rst_n = 1'b1;

      // ALU producer then immediate consumer: forwarded from EX output, no stall.
      step(1, 1, 2, 1, 1, 0, 1, 3, 0, 0);
      step(1, 3, 0, 1, 0, 0, 1, 8, 0, 0);
      check("t1_fwd_a", int'(FwdSelA), 1);
      idle(4);

      // LOAD then use: one stall cycle, then select from stage 2.
      base = exp_cnt;
      step(1, 0, 0, 0, 0, 0, 1, 5, 1, 0);
      step(1, 5, 0, 1, 0, 0, 1, 9, 0, 0);
      step(1, 5, 0, 1, 0, 0, 1, 9, 0, 0);
      check("t2_fwd_a", int'(FwdSelA), 2);
      check("t2_stalls", int'(StallCycles) - base, 1);
      idle(4);

      // MUL then use: two stalls, producer reaches WB so no forward.
      base = exp_cnt;
      step(1, 0, 0, 0, 0, 0, 1, 7, 2, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 7, 0, 1, 0, 1, 10, 0, 0);
      check("t3_fwd_b", int'(FwdSelB), 0);
      check("t3_stalls", int'(StallCycles) - base, 2);
      idle(4);

      // ALU / LOAD feeding an ID-stage branch compare.
      step(1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
      step(1, 4, 0, 1, 1, 1, 0, 0, 0, 0);
      step(1, 4, 0, 1, 1, 1, 0, 0, 0, 0);
      idle(4);
      step(1, 0, 0, 0, 0, 0, 1, 4, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 4, 0, 1, 1, 1, 0, 0, 0, 0);
      idle(4);

      // Flush hides a hazard; youngest producer wins.
      step(1, 0, 0, 0, 0, 0, 1, 6, 1, 0);
      step(1, 6, 0, 1, 0, 0, 1, 11, 0, 1);
      check("t5_flush_fwd", int'(FwdSelA), 0);
      idle(4);
      step(1, 0, 0, 0, 0, 0, 1, 6, 1, 0);
      step(1, 0, 0, 0, 0, 0, 1, 6, 0, 0);
      step(1, 6, 6, 1, 1, 0, 1, 12, 0, 0);
      check("t5_young_fwd", int'(FwdSelA), 1);
      idle(4);

      // Writes to r0 never create a hazard.
      step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);

      // Randomized traffic over a small register pool to provoke hazards.
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 99) < 85), $urandom_range(0, 7), $urandom_range(0, 7),
              ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 80),
              ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 70),
              $urandom_range(0, 7), $urandom_range(0, 3), ($urandom_range(0, 99) < 10));
      end
      idle(4);

      // Reset asserted mid-stall with a LOAD pending clears everything at once.
      step(1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
      step(1, 3, 0, 1, 0, 0, 1, 5, 1, 0);
      @(negedge Clk);
      IdValid = 1; IdRs = 5; IdUseRs = 1; IdUseRt = 0; IdEarlyUse = 0; IdWe = 0; Flush = 0;
      #1;
      check("t6_pre_stall", int'(Stall), 1);
      Rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_stall",  int'(Stall),       0);
      check("t6_bubble", int'(BubbleEx),    0);
      check("t6_fwd_a",  int'(FwdSelA),     0);
      check("t6_cnt",    int'(StallCycles), 0);
      @(negedge Clk);
      Rst_n = 1'b1;
      idle(2);
      step(1, 5, 0, 1, 0, 0, 1, 2, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
